sdf_stage_ctrl: RTL
===================

# sdf_stage_ctrl

Sequencing controller for one radix-2 single-delay-feedback (SDF) stage of the streaming FFT pipeline. It tracks each incoming frame, and drives the stage datapath's butterfly/bypass select, delay-line write enable and twiddle-ROM address. It also drains the delay line after the last sample and regenerates frame start/end/valid markers for the next stage. One instance sits beside each butterfly stage; its outputs chain into the next stage's controller.

## Interface
- LAYER, 12, log2 of stage block size; delay-line depth D = 2^(LAYER-1)
- FRAME_LOG2, 12, log2 of FFT frame length N; requires LAYER <= FRAME_LOG2
- DP_LAT, 3, datapath latency (cycles) from control alignment to stage output
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_start  in  1  first sample of frame
- in_end  in  1  last sample of frame
- in_valid  in  1  sample present this cycle
- bf_sel  out  1  0 = load delay line / emit difference, 1 = butterfly (emit sum)
- dl_we  out  1  delay-line shift enable
- tw_addr  out  FRAME_LOG2-1  twiddle ROM address
- tw_valid  out  1  current output takes a non-trivial twiddle
- out_start / out_end / out_valid  out  1 each  frame markers to next stage
- busy  out  1  state != IDLE
- err_overrun / err_len  out  1 each  single-cycle error pulses

## Operation
- States: IDLE, FILL, COMPUTE, FLUSH. Sample counter cnt has FRAME_LOG2 bits. In FILL/COMPUTE it advances only on in_valid. In FLUSH it advances every cycle.
- IDLE -> FILL on in_start & in_valid, with cnt = 0.
- FILL <-> COMPUTE toggles each D accepted samples. The toggle is bit LAYER-1 of cnt.
- After sample N-1 is accepted: -> FLUSH. If in_start & in_valid arrive on the very next cycle, the block goes -> FILL instead (back-to-back). In that case the new FILL carries the previous frame's differences.
- FLUSH runs D cycles with no input, then -> IDLE.
- bf_sel = 1 in COMPUTE, else 0.
- dl_we = in_valid in FILL/COMPUTE, 1 in FLUSH.
- tw_valid = 1 for difference outputs: FILL of any block except the frame's first, FLUSH, and back-to-back FILL.
- tw_addr = (cnt mod D) << (FRAME_LOG2-LAYER). It is zero when tw_valid = 0.
- Output samples are produced for positions D..N-1 plus the D flush cycles, N in total.
- out_start marks the first output; out_end marks the last output.
- in_start in FILL/COMPUTE, or in FLUSH without the back-to-back condition, is ignored and pulses err_overrun.
- in_end with cnt != N-1 pulses err_len. Frame length is always set by cnt, never by in_end.

## Timing
- All outputs registered.
- bf_sel, dl_we, tw_addr and tw_valid lag the accepted input sample by 1 cycle.
- out_start, out_valid and out_end lag the same event by 1+DP_LAT cycles. A DP_LAT-deep shift register carries them.
- Errors pulse 1 cycle after the offending input.
- Reset: every output is 0, state is IDLE, cnt is 0, and the shift register is cleared. Reset mid-frame aborts immediately with no flush and no out_end.
- in_valid gaps stall cnt and the phase, and deassert dl_we and out_valid for the matching cycles.

## Configuration
- SDF_STAGE_CTRL_ERR_EN defined: err_overrun and err_len are generated as above.
- SDF_STAGE_CTRL_ERR_EN undefined: the error logic is removed and both outputs are tied 0. Stray in_start is still ignored.

## Test plan
All cases use LAYER=3, FRAME_LOG2=4, DP_LAT=2 (D=4, N=16).
- Single frame, in_valid cycles 0-15: bf_sel 0 at 1-4, 1 at 5-8, 0 at 9-12, 1 at 13-16, 0 at flush 17-20. tw_valid at 9-12 and 17-20, with tw_addr 0,2,4,6. out_start at 7, out_valid 7-22, out_end at 22, busy low from 21.
- Same frame with in_valid low every third cycle: phase boundaries slip with the gaps, out_valid count is still exactly 16, out_end is 3 cycles after the last flush cycle.
- Two frames back-to-back (second in_start at cycle 16): no IDLE. Cycles 17-20 have tw_valid=1 and bf_sel=0. A single out_end is asserted for each frame, 16 out_valids apart in steady state.
- in_start at cycle 6 of a frame: err_overrun at 7, frame unaffected, one out_start only.
- in_end at cycle 10: err_len at 11, frame still runs 16 samples.
- rst at cycle 9, then a new frame: all outputs 0 at cycle 10, no out_end from the aborted frame, new frame behaves exactly as case 1.

Source files
------------

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencing controller for one radix-2 single-delay-feedback
// FFT stage. Tracks frame position, drives butterfly select, delay-line shift
// enable and twiddle address, drains the delay line after the last sample and
// regenerates frame markers for the next stage.
//
// Build option: define SDF_STAGE_CTRL_ERR_EN to generate the err_overrun_o /
// err_len_o pulses; otherwise both outputs are tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame in progress
// FILL    | loading delay line; outputs are differences (except block 0)
// COMPUTE | butterfly active, emitting sums
// FLUSH   | draining the last differences, one per cycle, no input

module sdf_stage_ctrl #(
    parameter int LAYER      = 12,
    parameter int FRAME_LOG2 = 12,
    parameter int DP_LAT     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_start_i,
    input  logic                  in_end_i,
    input  logic                  in_valid_i,
    output logic                  bf_sel_o,
    output logic                  dl_we_o,
    output logic [FRAME_LOG2-2:0] tw_addr_o,
    output logic                  tw_valid_o,
    output logic                  out_start_o,
    output logic                  out_end_o,
    output logic                  out_valid_o,
    output logic                  busy_o,
    output logic                  err_overrun_o,
    output logic                  err_len_o
);

    localparam int D  = 1 << (LAYER - 1);
    localparam int SH = FRAME_LOG2 - LAYER;
    localparam logic [FRAME_LOG2-1:0] CNT_MASK = FRAME_LOG2'(D - 1);
    localparam logic [FRAME_LOG2-1:0] CNT_D    = FRAME_LOG2'(D);
    localparam logic [FRAME_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, FILL, COMPUTE, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
    logic                  carry_q, carry_d;

    logic                  in_frame, b2b_win, start_now, accept, flush_now;
    logic                  carry_now, first_blk, phase, last;
    logic [FRAME_LOG2-1:0] idx, idx_p1, tw_idx;

    logic                  bf_sel_q, bf_sel_d;
    logic                  dl_we_q, dl_we_d;
    logic                  tw_valid_q, tw_valid_d;
    logic [FRAME_LOG2-2:0] tw_addr_q, tw_addr_d;
    logic                  busy_q, busy_d;
    logic [2:0]            mark_d;
    logic [2:0]            mark_q [0:DP_LAT];

    // A new frame may start from IDLE, or on the first flush cycle, in which
    // case its first block rides on the previous frame's pending differences.
    assign in_frame  = (state_q == FILL) || (state_q == COMPUTE);
    assign b2b_win   = (state_q == FLUSH) && (cnt_q == '0);
    assign start_now = in_valid_i & in_start_i & ((state_q == IDLE) | b2b_win);
    assign accept    = start_now | (in_frame & in_valid_i);
    assign flush_now = (state_q == FLUSH) & ~start_now;
    assign idx       = start_now ? '0 : cnt_q;
    assign idx_p1    = idx + FRAME_LOG2'(1);
    assign carry_now = start_now ? (state_q == FLUSH) : carry_q;
    assign first_blk = ((idx & ~CNT_MASK) == '0);
    assign phase     = idx[LAYER-1];
    assign last      = (idx == CNT_LAST);

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        if (accept) begin
            cnt_d   = idx_p1;
            carry_d = carry_now;
            if (last)
                state_d = FLUSH;
            else if (idx_p1[LAYER-1])
                state_d = COMPUTE;
            else
                state_d = FILL;
        end else if (flush_now) begin
            if (cnt_q == CNT_MASK) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + FRAME_LOG2'(1);
            end
        end
    end

    // Output decode for the sample (or flush slot) handled this cycle.
    always_comb begin
        bf_sel_d   = accept ? phase : (state_q == COMPUTE);
        dl_we_d    = accept | flush_now;
        tw_valid_d = accept ? (~phase & (~first_blk | carry_now)) : flush_now;
        tw_idx     = accept ? idx : cnt_q;
        tw_addr_d  = tw_valid_d ? (FRAME_LOG2-1)'((tw_idx & CNT_MASK) << SH) : '0;
        busy_d     = (state_q != IDLE) | start_now;
        mark_d     = 3'b000;
        if (accept) begin
            mark_d[2] = (idx == CNT_D);
            mark_d[1] = ~first_blk | carry_now;
            mark_d[0] = carry_now & first_blk & (idx == CNT_MASK);
        end else if (flush_now) begin
            mark_d[1] = 1'b1;
            mark_d[0] = (cnt_q == CNT_MASK);
        end
    end

    // State, counter and control-output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            bf_sel_q   <= 1'b0;
            dl_we_q    <= 1'b0;
            tw_valid_q <= 1'b0;
            tw_addr_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            bf_sel_q   <= bf_sel_d;
            dl_we_q    <= dl_we_d;
            tw_valid_q <= tw_valid_d;
            tw_addr_q  <= tw_addr_d;
            busy_q     <= busy_d;
        end
    end

    // Marker pipeline {start, valid, end} aligned to the datapath latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i <= DP_LAT; i++) mark_q[i] <= 3'b000;
        end else begin
            mark_q[0] <= mark_d;
            for (int i = 1; i <= DP_LAT; i++) mark_q[i] <= mark_q[i-1];
        end
    end

    assign bf_sel_o    = bf_sel_q;
    assign dl_we_o     = dl_we_q;
    assign tw_valid_o  = tw_valid_q;
    assign tw_addr_o   = tw_addr_q;
    assign busy_o      = busy_q;
    assign out_start_o = mark_q[DP_LAT][2];
    assign out_valid_o = mark_q[DP_LAT][1];
    assign out_end_o   = mark_q[DP_LAT][0];

`ifdef SDF_STAGE_CTRL_ERR_EN
    logic err_overrun_q, err_len_q;

    // Stray starts and length mismatches pulse one cycle after the input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_overrun_q <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            err_overrun_q <= in_start_i & in_valid_i & (in_frame | flush_now);
            err_len_q     <= accept & in_end_i & ~last;
        end
    end

    assign err_overrun_o = err_overrun_q;
    assign err_len_o     = err_len_q;
`else
    // Frame length comes from the counter alone, so in_end only feeds errors.
    logic unused_in_end;
    assign unused_in_end = in_end_i;
    assign err_overrun_o = 1'b0;
    assign err_len_o     = 1'b0;
`endif

endmodule
